// File: rtl/ysyx_22050133_axi_slave_sram_pkg.sv
// rtl/ysyx_22050133_axi_slave_sram_pkg.sv - shared AXI encodings, FSM state types and helpers
//
// Purpose: AXI burst/response/size encodings and the state enums used by the
// SRAM-backed AXI responder and its address helper.
// Ports:   none (package).

package ysyx_22050133_axi_slave_sram_pkg;

  // AXI burst type encodings
  localparam logic [1:0] ysyx_22050133_AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] ysyx_22050133_AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] ysyx_22050133_AXI_BURST_WRAP  = 2'b10;

  // AXI response encodings
  localparam logic [1:0] ysyx_22050133_AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] ysyx_22050133_AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] ysyx_22050133_AXI_RESP_DECERR = 2'b11;

  // AXI size encodings (log2 of bytes per beat)
  localparam logic [2:0] AXI_SIZE_BYTES_1 = 3'd0;
  localparam logic [2:0] AXI_SIZE_BYTES_2 = 3'd1;
  localparam logic [2:0] AXI_SIZE_BYTES_4 = 3'd2;
  localparam logic [2:0] AXI_SIZE_BYTES_8 = 3'd3;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } r_state_e;

  // Accumulate a burst's write response: DECERR dominates SLVERR, which
  // dominates OKAY, so an earlier decode error is never downgraded.
  function automatic logic [1:0] merge_resp(input logic [1:0] cur, input logic [1:0] beat);
    if (cur == ysyx_22050133_AXI_RESP_DECERR || beat == ysyx_22050133_AXI_RESP_DECERR) begin
      merge_resp = ysyx_22050133_AXI_RESP_DECERR;
    end else if (cur == ysyx_22050133_AXI_RESP_SLVERR || beat == ysyx_22050133_AXI_RESP_SLVERR) begin
      merge_resp = ysyx_22050133_AXI_RESP_SLVERR;
    end else begin
      merge_resp = ysyx_22050133_AXI_RESP_OKAY;
    end
  endfunction

endpackage

// File: rtl/ysyx_22050133_axi_slave_sram_if.sv
// rtl/ysyx_22050133_axi_slave_sram_if.sv - AXI4 channel bundle (no IDs) between core master and SRAM responder
//
// Purpose: groups the AW/W/B/AR/R channel signals.
// Modports:
//   master - drives valids, addresses, write data and the B/R readies
//   slave  - drives AW/W/AR readies, B response and R data/response/last

interface ysyx_22050133_axi_slave_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) ();

  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;

  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;

  logic                    b_valid;
  logic                    b_ready;
  logic [1:0]              b_resp;

  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;

  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;

  modport master (
    output aw_valid, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_resp,
    output b_ready,
    output ar_valid, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_resp,
    input  b_ready,
    input  ar_valid, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last,
    input  r_ready
  );

endinterface

// File: rtl/ysyx_22050133_axi_burst_addr.sv
// rtl/ysyx_22050133_axi_burst_addr.sv - combinational beat-address step, SRAM word index and range check
//
// Purpose: given the current beat address, size and burst type, produce the
// next beat address, the 64-bit word index into the SRAM and an in-range flag.
// Ports:
//   addr      in   current beat byte address
//   size      in   log2 bytes per beat
//   burst     in   burst type
//   next_addr out  address of the following beat
//   word_idx  out  SRAM word index of addr (valid only when in_range)
//   in_range  out  addr falls inside [BASE_ADDR, BASE_ADDR + 8*MEM_WORDS)

module ysyx_22050133_axi_burst_addr
  import ysyx_22050133_axi_slave_sram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    IDX_W      = $clog2(MEM_WORDS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [IDX_W-1:0]      word_idx,
  output logic                  in_range
);

  logic [2:0]            eff_size;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] offset;

  always_comb begin
    // Sizes wider than the 64-bit bus are illegal; clamp so the step never
    // skips whole words.
    eff_size = (size > AXI_SIZE_BYTES_8) ? AXI_SIZE_BYTES_8 : size;
    step     = ADDR_WIDTH'(1) << eff_size;
    offset   = addr - BASE_ADDR;

    // WRAP and the reserved encoding both step like INCR.
    case (burst)
      ysyx_22050133_AXI_BURST_FIXED: next_addr = addr;
      ysyx_22050133_AXI_BURST_INCR,
      ysyx_22050133_AXI_BURST_WRAP:  next_addr = (addr & ~(step - ADDR_WIDTH'(1))) + step;
      default:                       next_addr = (addr & ~(step - ADDR_WIDTH'(1))) + step;
    endcase

    word_idx = offset[IDX_W+2:3];
    // Below-base addresses make offset wrap huge, but check explicitly so the
    // intent does not rely on the wrap.
    in_range = (addr >= BASE_ADDR) && ((offset >> 3) < ADDR_WIDTH'(MEM_WORDS));
  end

endmodule

// File: rtl/ysyx_22050133_axi_slave_sram.sv
// rtl/ysyx_22050133_axi_slave_sram.sv - AXI4 responder backed by an on-chip byte-addressable SRAM
//
// Purpose: memory target for the core's AXI master. Independent write
// (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_FETCH/R_DATA) state machines
// share one SRAM array and may run concurrently.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-low reset
//   axi  slave modport of the AXI channel bundle

module ysyx_22050133_axi_slave_sram
  import ysyx_22050133_axi_slave_sram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_22050133_axi_slave_sram_if.slave axi
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int STRB_W = DATA_WIDTH / 8;

  // Contents are deliberately not reset.
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // ---------------------------------------------------------------- write path
  w_state_e              w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [7:0]            w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic [1:0]            w_err;
  logic                  aw_ready_q;
  logic                  w_ready_q;
  logic                  b_valid_q;
  logic [1:0]            b_resp_q;

  logic [ADDR_WIDTH-1:0] w_next;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range;
  logic                  w_fire;
  logic                  w_last_beat;
  logic [1:0]            w_beat_err;
  logic [1:0]            w_err_next;

  ysyx_22050133_axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_w_addr (
    .addr      (w_addr),
    .size      (w_size),
    .burst     (w_burst),
    .next_addr (w_next),
    .word_idx  (w_idx),
    .in_range  (w_in_range)
  );

  always_comb begin
    w_fire      = (w_state == W_DATA) && axi.w_valid && w_ready_q;
    w_last_beat = (w_cnt == w_len);
    // The beat counter, not w_last, ends the burst; a disagreeing w_last is
    // only reported.
    if (!w_in_range) begin
      w_beat_err = ysyx_22050133_AXI_RESP_DECERR;
    end else if (axi.w_last != w_last_beat) begin
      w_beat_err = ysyx_22050133_AXI_RESP_SLVERR;
    end else begin
      w_beat_err = ysyx_22050133_AXI_RESP_OKAY;
    end
    w_err_next = merge_resp(w_err, w_beat_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state    <= W_IDLE;
      w_addr     <= '0;
      w_len      <= '0;
      w_cnt      <= '0;
      w_size     <= '0;
      w_burst    <= '0;
      w_err      <= ysyx_22050133_AXI_RESP_OKAY;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= ysyx_22050133_AXI_RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (axi.aw_valid && aw_ready_q) begin
            w_addr     <= axi.aw_addr;
            w_len      <= axi.aw_len;
            w_size     <= axi.aw_size;
            w_burst    <= axi.aw_burst;
            w_cnt      <= '0;
            w_err      <= ysyx_22050133_AXI_RESP_OKAY;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            w_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_err <= w_err_next;
            if (w_last_beat) begin
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
              b_resp_q  <= w_err_next;
              w_state   <= W_RESP;
            end else begin
              w_cnt  <= w_cnt + 8'd1;
              w_addr <= w_next;
            end
          end
        end
        W_RESP: begin
          if (axi.b_ready) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_state    <= W_IDLE;
          end
        end
        default: begin
          w_state    <= W_IDLE;
          aw_ready_q <= 1'b1;
          w_ready_q  <= 1'b0;
          b_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane writes; out-of-range beats are dropped here and flagged above.
  always_ff @(posedge clk) begin
    if (w_fire && w_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi.w_strb[b]) begin
          mem[w_idx][b*8 +: 8] <= axi.w_data[b*8 +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------------- read path
  r_state_e              r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  ar_ready_q;
  logic                  r_valid_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic [1:0]            r_resp_q;
  logic                  r_last_q;

  logic [ADDR_WIDTH-1:0] r_next;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_in_range;

  ysyx_22050133_axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_r_addr (
    .addr      (r_addr),
    .size      (r_size),
    .burst     (r_burst),
    .next_addr (r_next),
    .word_idx  (r_idx),
    .in_range  (r_in_range)
  );

  // The SRAM read happens on the edge leaving R_FETCH. A write to the same
  // word on that edge is not yet visible, giving read-before-write ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= R_IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= ysyx_22050133_AXI_RESP_OKAY;
      r_last_q   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (axi.ar_valid && ar_ready_q) begin
            r_addr     <= axi.ar_addr;
            r_len      <= axi.ar_len;
            r_size     <= axi.ar_size;
            r_burst    <= axi.ar_burst;
            r_cnt      <= '0;
            ar_ready_q <= 1'b0;
            r_state    <= R_FETCH;
          end
        end
        R_FETCH: begin
          r_valid_q <= 1'b1;
          r_data_q  <= r_in_range ? mem[r_idx] : '0;
          r_resp_q  <= r_in_range ? ysyx_22050133_AXI_RESP_OKAY : ysyx_22050133_AXI_RESP_DECERR;
          r_last_q  <= (r_cnt == r_len);
          r_state   <= R_DATA;
        end
        R_DATA: begin
          if (axi.r_ready) begin
            r_valid_q <= 1'b0;
            if (r_last_q) begin
              r_last_q   <= 1'b0;
              ar_ready_q <= 1'b1;
              r_state    <= R_IDLE;
            end else begin
              r_addr  <= r_next;
              r_cnt   <= r_cnt + 8'd1;
              r_state <= R_FETCH;
            end
          end
        end
        default: begin
          r_state    <= R_IDLE;
          ar_ready_q <= 1'b1;
          r_valid_q  <= 1'b0;
          r_last_q   <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------ outputs
  assign axi.aw_ready = aw_ready_q;
  assign axi.w_ready  = w_ready_q;
  assign axi.b_valid  = b_valid_q;
  assign axi.b_resp   = b_resp_q;
  assign axi.ar_ready = ar_ready_q;
  assign axi.r_valid  = r_valid_q;
  assign axi.r_data   = r_data_q;
  assign axi.r_resp   = r_resp_q;
  assign axi.r_last   = r_last_q;

endmodule

// File: tb/tb_ysyx_22050133_axi_slave_sram.sv
// tb/tb_ysyx_22050133_axi_slave_sram.sv - directed self-checking bench for the AXI SRAM responder

module tb_ysyx_22050133_axi_slave_sram;
  import ysyx_22050133_axi_slave_sram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  ysyx_22050133_axi_slave_sram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

  ysyx_22050133_axi_slave_sram #(
    .DATA_WIDTH (64),
    .ADDR_WIDTH (32),
    .MEM_WORDS  (4096),
    .BASE_ADDR  (32'h8000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .axi (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] wr_data [16];
  logic [7:0]  wr_strb [16];
  logic        wr_last [16];
  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [1:0]  bresp;
  logic [63:0] burst_words [4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
    bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb = '0; bus.w_last = 1'b0;
    bus.b_ready  = 1'b0;
    bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0;
    bus.r_ready  = 1'b0;
  endtask

  // Beats come from wr_data/wr_strb/wr_last, filled by the caller.
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.aw_valid = 1'b1; bus.aw_addr = addr; bus.aw_len = len; bus.aw_size = size; bus.aw_burst = burst;
    n = 0;
    while (!bus.aw_ready && n < 20) begin @(negedge clk); n++; end
    check_eq("aw_handshake", bus.aw_ready, 1);
    @(negedge clk);
    bus.aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.w_valid = 1'b1; bus.w_data = wr_data[i]; bus.w_strb = wr_strb[i]; bus.w_last = wr_last[i];
      n = 0;
      while (!bus.w_ready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) check_eq("w_ready_timeout", bus.w_ready, 1);
      @(negedge clk);
    end
    bus.w_valid = 1'b0; bus.w_last = 1'b0;
    check_eq("b_valid_after_last_w", bus.b_valid, 1);
    resp = bus.b_resp;
    bus.b_ready = 1'b1;
    @(negedge clk);
    bus.b_ready = 1'b0;
    check_eq("b_valid_cleared", bus.b_valid, 0);
  endtask

  // Each beat must appear 2 cycles after the AR or previous R handshake.
  // With stall set, r_ready is held low for one cycle per beat to check hold.
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input bit stall);
    int n;
    int lat;
    logic [63:0] held;
    @(negedge clk);
    bus.ar_valid = 1'b1; bus.ar_addr = addr; bus.ar_len = len; bus.ar_size = size; bus.ar_burst = burst;
    n = 0;
    while (!bus.ar_ready && n < 20) begin @(negedge clk); n++; end
    check_eq("ar_handshake", bus.ar_ready, 1);
    @(negedge clk);
    bus.ar_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      lat = 1;
      while (!bus.r_valid && lat < 20) begin @(negedge clk); lat++; end
      check_eq("r_latency", lat, 2);
      if (stall) begin
        held = bus.r_data;
        @(negedge clk);
        check_eq("r_valid_held", bus.r_valid, 1);
        check_eq("r_data_held", bus.r_data, held);
      end
      bus.r_ready = 1'b1;
      rd_data[i] = bus.r_data;
      rd_resp[i] = bus.r_resp;
      rd_last[i] = bus.r_last;
      @(negedge clk);
      bus.r_ready = 1'b0;
    end
  endtask

  initial begin
    burst_words[0] = 64'h2222_2222_0000_0002;
    burst_words[1] = 64'h3333_3333_0000_0003;
    burst_words[2] = 64'h4444_4444_0000_0004;
    burst_words[3] = 64'h5555_5555_0000_0005;

    drive_idle();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_aw_ready", bus.aw_ready, 1);
    check_eq("rst_ar_ready", bus.ar_ready, 1);
    check_eq("rst_w_ready",  bus.w_ready,  0);
    check_eq("rst_b_valid",  bus.b_valid,  0);
    check_eq("rst_r_valid",  bus.r_valid,  0);
    check_eq("rst_r_last",   bus.r_last,   0);
    check_eq("rst_r_data",   bus.r_data,   0);
    check_eq("rst_b_resp",   bus.b_resp,   0);
    check_eq("rst_r_resp",   bus.r_resp,   0);
    rst = 1'b1;
    @(negedge clk);

    // Full-word baseline for word 0, then a 4-byte write into its upper half
    wr_data[0] = 64'hDEAD_BEEF_CAFE_F00D; wr_strb[0] = 8'hFF; wr_last[0] = 1'b1;
    axi_write(32'h8000_0000, 8'd0, AXI_SIZE_BYTES_8, ysyx_22050133_AXI_BURST_INCR, bresp);
    check_eq("wr_base_bresp", bresp, 2'b00);
    wr_data[0] = 64'h1122_3344_5566_7788; wr_strb[0] = 8'hF0; wr_last[0] = 1'b1;
    axi_write(32'h8000_0004, 8'd0, AXI_SIZE_BYTES_4, ysyx_22050133_AXI_BURST_INCR, bresp);
    check_eq("wr_single_bresp", bresp, 2'b00);

    axi_read(32'h8000_0000, 8'd0, AXI_SIZE_BYTES_8, ysyx_22050133_AXI_BURST_INCR, 1'b0);
    check_eq("rd_back_upper", rd_data[0][63:32], 32'h1122_3344);
    check_eq("rd_back_word",  rd_data[0], 64'h1122_3344_CAFE_F00D);
    check_eq("rd_back_resp",  rd_resp[0], 2'b00);
    check_eq("rd_back_last",  rd_last[0], 1'b1);

    // INCR write burst to words 2..5, then stalled INCR read burst
    for (int i = 0; i < 4; i++) begin
      wr_data[i] = burst_words[i]; wr_strb[i] = 8'hFF; wr_last[i] = (i == 3);
    end
    axi_write(32'h8000_0010, 8'd3, AXI_SIZE_BYTES_8, ysyx_22050133_AXI_BURST_INCR, bresp);
    check_eq("wr_burst_bresp", bresp, 2'b00);
    axi_read(32'h8000_0010, 8'd3, AXI_SIZE_BYTES_8, ysyx_22050133_AXI_BURST_INCR, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rd_burst_data%0d", i), rd_data[i], burst_words[i]);
      check_eq($sformatf("rd_burst_last%0d", i), rd_last[i], (i == 3) ? 1'b1 : 1'b0);
      check_eq($sformatf("rd_burst_resp%0d", i), rd_resp[i], 2'b00);
    end

    // FIXED burst repeats the same word
    axi_read(32'h8000_0018, 8'd1, AXI_SIZE_BYTES_8, ysyx_22050133_AXI_BURST_FIXED, 1'b0);
    check_eq("rd_fixed_data0", rd_data[0], 64'h3333_3333_0000_0003);
    check_eq("rd_fixed_data1", rd_data[1], 64'h3333_3333_0000_0003);
    check_eq("rd_fixed_last0", rd_last[0], 1'b0);
    check_eq("rd_fixed_last1", rd_last[1], 1'b1);

    // Range boundaries: last word is valid, one past it and below base are DECERR
    wr_data[0] = 64'h0FED_CBA9_8765_4321; wr_strb[0] = 8'hFF; wr_last[0] = 1'b1;
    axi_write(32'h8000_7FF8, 8'd0, AXI_SIZE_BYTES_8, ysyx_22050133_AXI_BURST_INCR, bresp);
    check_eq("wr_top_bresp", bresp, 2'b00);
    axi_read(32'h8000_7FF8, 8'd0, AXI_SIZE_BYTES_8, ysyx_22050133_AXI_BURST_INCR, 1'b0);
    check_eq("rd_top_data", rd_data[0], 64'h0FED_CBA9_8765_4321);
    check_eq("rd_top_resp", rd_resp[0], 2'b00);
    axi_write(32'h8000_8000, 8'd0, AXI_SIZE_BYTES_8, ysyx_22050133_AXI_BURST_INCR, bresp);
    check_eq("wr_past_top_bresp", bresp, 2'b11);
    axi_read(32'h8000_8000, 8'd0, AXI_SIZE_BYTES_8, ysyx_22050133_AXI_BURST_INCR, 1'b0);
    check_eq("rd_past_top_data", rd_data[0], 64'h0);
    check_eq("rd_past_top_resp", rd_resp[0], 2'b11);
    axi_read(32'h7FFF_FFF8, 8'd0, AXI_SIZE_BYTES_8, ysyx_22050133_AXI_BURST_INCR, 1'b0);
    check_eq("rd_below_base_data", rd_data[0], 64'h0);
    check_eq("rd_below_base_resp", rd_resp[0], 2'b11);
    check_eq("rd_below_base_last", rd_last[0], 1'b1);

    // Early w_last on a 2-beat write gives SLVERR after both beats
    wr_data[0] = 64'h1; wr_strb[0] = 8'hFF; wr_last[0] = 1'b1;
    wr_data[1] = 64'h2; wr_strb[1] = 8'hFF; wr_last[1] = 1'b0;
    axi_write(32'h8000_0040, 8'd1, AXI_SIZE_BYTES_8, ysyx_22050133_AXI_BURST_INCR, bresp);
    check_eq("wr_early_last_bresp", bresp, 2'b10);

    // Concurrent AW+AR to word 6: the read sees the value before the write
    wr_data[0] = 64'hAAAA_0000_0000_0006; wr_strb[0] = 8'hFF; wr_last[0] = 1'b1;
    axi_write(32'h8000_0030, 8'd0, AXI_SIZE_BYTES_8, ysyx_22050133_AXI_BURST_INCR, bresp);
    @(negedge clk);
    bus.aw_valid = 1'b1; bus.aw_addr = 32'h8000_0030; bus.aw_len = 8'd0;
    bus.aw_size = AXI_SIZE_BYTES_8; bus.aw_burst = ysyx_22050133_AXI_BURST_INCR;
    bus.ar_valid = 1'b1; bus.ar_addr = 32'h8000_0030; bus.ar_len = 8'd0;
    bus.ar_size = AXI_SIZE_BYTES_8; bus.ar_burst = ysyx_22050133_AXI_BURST_INCR;
    check_eq("cc_aw_ready", bus.aw_ready, 1);
    check_eq("cc_ar_ready", bus.ar_ready, 1);
    @(negedge clk);
    bus.aw_valid = 1'b0; bus.ar_valid = 1'b0;
    check_eq("cc_w_ready", bus.w_ready, 1);
    check_eq("cc_r_valid_fetch", bus.r_valid, 0);
    bus.w_valid = 1'b1; bus.w_data = 64'hBBBB_0000_0000_0006; bus.w_strb = 8'hFF; bus.w_last = 1'b1;
    @(negedge clk);
    bus.w_valid = 1'b0; bus.w_last = 1'b0;
    check_eq("cc_r_valid", bus.r_valid, 1);
    check_eq("cc_r_data_old", bus.r_data, 64'hAAAA_0000_0000_0006);
    check_eq("cc_b_valid", bus.b_valid, 1);
    check_eq("cc_b_resp", bus.b_resp, 2'b00);
    bus.r_ready = 1'b1; bus.b_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0; bus.b_ready = 1'b0;
    axi_read(32'h8000_0030, 8'd0, AXI_SIZE_BYTES_8, ysyx_22050133_AXI_BURST_INCR, 1'b0);
    check_eq("cc_r_data_new", rd_data[0], 64'hBBBB_0000_0000_0006);

    // Reset in the middle of a len-7 read burst
    @(negedge clk);
    bus.ar_valid = 1'b1; bus.ar_addr = 32'h8000_0010; bus.ar_len = 8'd7;
    bus.ar_size = AXI_SIZE_BYTES_8; bus.ar_burst = ysyx_22050133_AXI_BURST_INCR;
    check_eq("mid_ar_ready", bus.ar_ready, 1);
    @(negedge clk);
    bus.ar_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_r_valid", bus.r_valid, 1);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_r_valid", bus.r_valid, 0);
    check_eq("mid_rst_r_last", bus.r_last, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ar_ready", bus.ar_ready, 1);
    check_eq("post_rst_aw_ready", bus.aw_ready, 1);
    check_eq("post_rst_r_valid", bus.r_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
